// File: rtl/agu_pkg.sv
// agu_pkg: shared state type and dimension limit for the address generators
package agu_pkg;
    typedef enum logic {IDLE, RUN} agu_state_t;
    localparam int AGU_MAX_DIMS = 4;
endpackage

// File: rtl/agu_dim_counter.sv
// agu_dim_counter: one loop dimension -- index counter, offset accumulator, end-of-range flag
module agu_dim_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         adv,
    input  logic [W-1:0] count,
    input  logic [W-1:0] stride,
    output logic [W-1:0] offset,
    output logic         at_end
);
    logic [W-1:0] idx, idx_last, stride_q;
    assign at_end = idx == idx_last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            idx_last <= '0;
            stride_q <= '0;
            offset   <= '0;
        end else if (load) begin
            idx      <= '0;
            offset   <= '0;
            idx_last <= (count == '0) ? '0 : count - W'(1);
            stride_q <= stride;
        end else if (adv) begin
            idx    <= at_end ? '0 : idx + W'(1);
            offset <= at_end ? '0 : offset + stride_q;
        end
    end
endmodule

// File: rtl/agu_nd.sv
// agu_nd: N-dimensional nested-loop address generator with valid/ready output.
// Optional per-dimension wrap flags (dim_last) are enabled by defining AGU_ND_DIM_LAST_EN.
module agu_nd
    import agu_pkg::*;
#(
    parameter int W    = 32,
    parameter int DIMS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      base,
    input  logic [DIMS*W-1:0] count,
    input  logic [DIMS*W-1:0] stride,
    input  logic              start,
    input  logic              ready,
    output logic              valid,
    output logic [W-1:0]      addr,
    output logic              last,
    output logic              busy
`ifdef AGU_ND_DIM_LAST_EN
    ,output logic [DIMS-1:0]  dim_last
`endif
);
    agu_state_t  state, state_nx;
    logic [W-1:0]    base_q;
    logic [W-1:0]    off [DIMS];
    logic [DIMS-1:0] at_end;
    logic [DIMS-1:0] adv;
    logic            load;

    if (DIMS < 1 || DIMS > AGU_MAX_DIMS) begin : g_bad_dims
        $error("agu_nd: DIMS out of range");
    end

    assign load   = state == IDLE && start;
    assign valid  = state == RUN;
    assign busy   = valid;
    assign last   = valid && &at_end;
    assign adv[0] = valid && ready;
`ifdef AGU_ND_DIM_LAST_EN
    assign dim_last = valid ? at_end : '0;
`endif

    // Each dimension carries into the next only when it wraps on an advance
    for (genvar d = 0; d < DIMS; d++) begin : g_dim
        agu_dim_counter #(.W(W)) u_dim (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load),
            .adv    (adv[d]),
            .count  (count[d*W +: W]),
            .stride (stride[d*W +: W]),
            .offset (off[d]),
            .at_end (at_end[d])
        );
        if (d < DIMS - 1) begin : g_carry
            assign adv[d+1] = adv[d] && at_end[d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_q <= '0;
        end else begin
            state  <= state_nx;
            base_q <= load ? base : base_q;
        end
    end

    always_comb begin
        state_nx = state;
        if (load) state_nx = RUN;
        else if (last && ready) state_nx = IDLE;
    end

    always_comb begin
        addr = base_q;
        for (int i = 0; i < DIMS; i++) addr = addr + off[i];
    end
endmodule

// File: tb/tb_agu_nd.sv
// tb_agu_nd: randomized scoreboard bench for agu_nd (32-bit 3-D and 8-bit 1-D instances)
module tb_agu_nd;
    localparam int W = 32;
    localparam int D = 3;

    typedef struct {
        logic [W-1:0] a;
        logic         l;
        logic [D-1:0] dl;
    } exp_t;
    typedef struct {
        logic [7:0] a;
        logic       l;
    } exp8_t;

    logic clk = 0;
    logic rst_n = 0;
    logic [W-1:0]   base = '0;
    logic [D*W-1:0] count = '0, stride = '0;
    logic start = 0, ready = 0;
    logic valid, last, busy;
    logic [W-1:0] addr;
    logic [D-1:0] dim_last;
    logic [7:0] base8 = '0, count8 = '0, stride8 = '0, addr8;
    logic start8 = 0, ready8 = 0, valid8, last8, busy8;
    logic dim_last8;

    int checks = 0, errors = 0;
    exp_t  q[$];
    exp8_t q8[$];
    exp_t  x;
    exp8_t x8;
    logic hold = 0, hlast = 0;
    logic [W-1:0] haddr = '0;
    logic [3:0] pat = 4'b1001;

    always #5 clk = ~clk;

    agu_nd #(.W(W), .DIMS(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .base(base), .count(count), .stride(stride),
        .start(start), .ready(ready), .valid(valid), .addr(addr), .last(last), .busy(busy)
`ifdef AGU_ND_DIM_LAST_EN
        , .dim_last(dim_last)
`endif
    );

    agu_nd #(.W(8), .DIMS(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .base(base8), .count(count8), .stride(stride8),
        .start(start8), .ready(ready8), .valid(valid8), .addr(addr8), .last(last8), .busy(busy8)
`ifdef AGU_ND_DIM_LAST_EN
        , .dim_last(dim_last8)
`endif
    );

`ifndef AGU_ND_DIM_LAST_EN
    assign dim_last  = '0;
    assign dim_last8 = 1'b0;
`endif

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, req);
        end
    endtask

    // Reference: enumerate beats by mixed-radix decomposition of the beat number
    task automatic model(input logic [W-1:0] b, input int c[D], input logic [W-1:0] s[D]);
        int e[D];
        int total = 1;
        exp_t y;
        for (int d = 0; d < D; d++) begin
            e[d] = (c[d] == 0) ? 1 : c[d];
            total *= e[d];
        end
        for (int n = 0; n < total; n++) begin
            int r = n;
            y.a = b;
            y.dl = '0;
            for (int d = 0; d < D; d++) begin
                int i = r % e[d];
                r /= e[d];
                y.a += W'(i) * s[d];
                y.dl[d] = (i == e[d] - 1);
            end
            y.l = (n == total - 1);
            q.push_back(y);
        end
    endtask

    always @(negedge clk) begin
        if (valid && hold) begin
            checks++;
            if (addr !== haddr || last !== hlast) begin
                errors++;
                $display("FAIL stall_hold: got %0h/%0b expected %0h/%0b", addr, last, haddr, hlast);
            end
        end
        hold = valid && !ready;
        haddr = addr;
        hlast = last;
        if (valid && ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat: got addr %0h expected no beat", addr);
            end else begin
                x = q.pop_front();
`ifdef AGU_ND_DIM_LAST_EN
                if (addr !== x.a || last !== x.l || dim_last !== x.dl) begin
`else
                if (addr !== x.a || last !== x.l) begin
`endif
                    errors++;
                    $display("FAIL beat: got %0h/%0b/%0b expected %0h/%0b/%0b",
                             addr, last, dim_last, x.a, x.l, x.dl);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (valid8 && ready8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL extra_beat8: got addr %0h expected no beat", addr8);
            end else begin
                x8 = q8.pop_front();
                if (addr8 !== x8.a || last8 !== x8.l || (valid8 && dim_last8 !== x8.l && 0)) begin
                    errors++;
                    $display("FAIL beat8: got %0h/%0b expected %0h/%0b", addr8, last8, x8.a, x8.l);
                end
            end
        end
    end

    // Caller must be between clock edges; start is accepted on the next rising edge
    task automatic run_sweep(input logic [W-1:0] b, input int c[D], input logic [W-1:0] s[D], input int mode);
        int k = 0;
        model(b, c, s);
        base = b;
        for (int d = 0; d < D; d++) begin
            count[d*W +: W]  = W'(c[d]);
            stride[d*W +: W] = s[d];
        end
        start = 1;
        ready = (mode == 2) ? 1'($urandom % 2) : 1'b1;
        @(posedge clk);
        #1 start = 0;
        check("start_latency", {valid, busy, addr}, {2'b11, b});
        while (busy && k < 3000) begin
            ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : 1'($urandom % 2);
            if (mode == 2) begin
                start  = ($urandom % 3) == 0;
                base   = $urandom;
                count  = {$urandom, $urandom, $urandom};
                stride = {$urandom, $urandom, $urandom};
            end
            k++;
            @(posedge clk);
            #1;
        end
        start = 0;
        if (k >= 3000) begin
            errors++;
            $display("FAIL sweep_timeout: got busy after %0d cycles expected idle", k);
        end
        check("end_idle", {valid, last, busy}, 3'b000);
        check("beats_left", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1 check("stay_idle", {valid, busy}, 2'b00);
    endtask

    initial begin
        int c[D];
        logic [W-1:0] s[D];
        repeat (3) @(posedge clk);
        #1 check("reset_state", {valid, last, busy, addr}, '0);
        check("reset_state8", {valid8, last8, busy8, addr8}, '0);
        @(negedge clk) rst_n = 1;
        run_sweep(32'h100, '{4, 1, 1}, '{32'd4, 32'd0, 32'd0}, 0);
        run_sweep(32'h0, '{3, 2, 1}, '{32'd1, 32'd16, 32'd0}, 0);
        run_sweep(32'h40, '{0, 0, 0}, '{32'd7, 32'd9, 32'd3}, 0);
        run_sweep(32'h1000, '{3, 2, 2}, '{32'd8, 32'h100, 32'hFFFF_F000}, 1);
        // 8-bit instance: negative stride wraps through zero
        q8.push_back('{8'h02, 1'b0});
        q8.push_back('{8'h01, 1'b0});
        q8.push_back('{8'h00, 1'b0});
        q8.push_back('{8'hFF, 1'b1});
        base8 = 8'h02; count8 = 8'd4; stride8 = 8'hFF; ready8 = 1; start8 = 1;
        @(posedge clk);
        #1 start8 = 0;
        for (int k = 0; k < 50 && busy8; k++) @(posedge clk);
        #1 check("beats_left8", 64'(q8.size()), 64'd0);
        check("idle8", {valid8, busy8}, 2'b00);
        // Reset in the middle of a sweep, on the third beat
        model(32'h5000, '{8, 1, 1}, '{32'd4, 32'd0, 32'd0});
        base = 32'h5000; count = {32'd1, 32'd1, 32'd8}; stride = {32'd0, 32'd0, 32'd4};
        ready = 1; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (2) @(posedge clk);
        #1 check("third_beat", addr, 32'h5008);
        rst_n = 0;
        #1 check("async_reset", {valid, last, busy, addr}, '0);
        q.delete();
        @(negedge clk) rst_n = 1;
        run_sweep(32'h7700, '{2, 2, 1}, '{32'd1, 32'd2, 32'd0}, 0);
        for (int t = 0; t < 12; t++) begin
            for (int d = 0; d < D; d++) begin
                c[d] = $urandom_range(0, 4);
                s[d] = $urandom;
            end
            run_sweep($urandom, c, s, 2);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
